// File: rtl/fp_pkg.sv
// Shared types for the FMA result-collection stage: buffered entry layout and default sizes.
package fp_pkg;
    localparam int FP_TAG_WIDTH     = 5;
    localparam int FP_STAT_WIDTH    = 5;
    localparam int FP_RES_BUF_DEPTH = 4;

    typedef struct packed {
        logic [FP_TAG_WIDTH-1:0]  tag;
        logic [31:0]              res;
        logic [FP_STAT_WIDTH-1:0] status;
    } fp_res_entry_t;
endpackage

// File: rtl/fp_sync_fifo.sv
// Generic synchronous FIFO, head visible combinationally; push dropped when full, pop ignored when empty.
module fp_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_dat,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_pop_dat,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  w_push;
    logic                  w_pop;

    assign o_full    = (r_count == LP_DEPTH);
    assign o_empty   = (r_count == '0);
    assign w_push    = i_push & ~o_full;
    assign w_pop     = i_pop & ~o_empty;
    assign o_pop_dat = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/fp_fma_result_buf.sv
// Pairs FMA results with in-order issue tags and buffers them for a valid/ready consumer.
// Result visible one cycle after fma_valid_i; credits stop issue once DEPTH ops are in flight.
module fp_fma_result_buf
    import fp_pkg::*;
#(
    parameter int DEPTH      = FP_RES_BUF_DEPTH,
    parameter int TAG_WIDTH  = FP_TAG_WIDTH,
    parameter int STAT_WIDTH = FP_STAT_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         issue_valid_i,
    input  logic [TAG_WIDTH-1:0]         issue_tag_i,
    output logic                         issue_ready_o,
    input  logic                         fma_valid_i,
    input  logic [31:0]                  fma_res_i,
    input  logic [STAT_WIDTH-1:0]        fma_status_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [31:0]                  out_res_o,
    output logic [TAG_WIDTH-1:0]         out_tag_o,
    output logic [STAT_WIDTH-1:0]        out_status_o,
    output logic                         err_o,
    output logic [$clog2(DEPTH+1)-1:0]   inflight_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
    localparam int EW = $bits(fp_res_entry_t);

    logic [CW-1:0]        r_cnt;
    logic                 r_err;
    logic                 w_issue;
    logic                 w_drain;
    logic                 w_tag_full;
    logic                 w_tag_empty;
    logic [TAG_WIDTH-1:0] w_tag_head;
    logic                 w_res_push;
    logic                 w_res_full;
    logic                 w_res_empty;
    logic [EW-1:0]        w_res_dat;
    fp_res_entry_t        w_push_ent;
    fp_res_entry_t        w_head_ent;

    assign issue_ready_o = (r_cnt < LP_DEPTH);
    assign w_issue       = issue_valid_i & issue_ready_o;
    assign w_drain       = out_valid_o & out_ready_i;
    // A result with no outstanding tag has nothing to pair with, so it is dropped.
    assign w_res_push    = fma_valid_i & ~w_tag_empty & ~w_res_full;

    fp_sync_fifo #(.DATA_WIDTH(TAG_WIDTH), .DEPTH(DEPTH)) u_tag_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_push     (w_issue & ~w_tag_full),
        .i_push_dat (issue_tag_i),
        .i_pop      (fma_valid_i),
        .o_pop_dat  (w_tag_head),
        .o_full     (w_tag_full),
        .o_empty    (w_tag_empty)
    );

    assign w_push_ent.tag    = w_tag_head;
    assign w_push_ent.res    = fma_res_i;
    assign w_push_ent.status = fma_status_i;

    fp_sync_fifo #(.DATA_WIDTH(EW), .DEPTH(DEPTH)) u_res_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_push     (w_res_push),
        .i_push_dat (w_push_ent),
        .i_pop      (out_ready_i),
        .o_pop_dat  (w_res_dat),
        .o_full     (w_res_full),
        .o_empty    (w_res_empty)
    );

    // Head is masked while empty so outputs read zero out of reset.
    assign w_head_ent   = fp_res_entry_t'(w_res_dat);
    assign out_valid_o  = ~w_res_empty;
    assign out_tag_o    = out_valid_o ? w_head_ent.tag    : '0;
    assign out_res_o    = out_valid_o ? w_head_ent.res    : '0;
    assign out_status_o = out_valid_o ? w_head_ent.status : '0;
    assign err_o        = r_err;
    assign inflight_o   = r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            case ({w_issue, w_drain})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
            if ((issue_valid_i & ~issue_ready_o) | (fma_valid_i & w_tag_empty)) begin
                r_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fp_fma_result_buf.sv
// Directed-vector bench for fp_fma_result_buf with hand-computed expectations.
module tb_fp_fma_result_buf;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        issue_valid_i = 1'b0;
    logic [4:0]  issue_tag_i = '0;
    logic        issue_ready_o;
    logic        fma_valid_i = 1'b0;
    logic [31:0] fma_res_i = '0;
    logic [4:0]  fma_status_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_res_o;
    logic [4:0]  out_tag_o;
    logic [4:0]  out_status_o;
    logic        err_o;
    logic [2:0]  inflight_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    fp_fma_result_buf dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .issue_valid_i (issue_valid_i),
        .issue_tag_i   (issue_tag_i),
        .issue_ready_o (issue_ready_o),
        .fma_valid_i   (fma_valid_i),
        .fma_res_i     (fma_res_i),
        .fma_status_i  (fma_status_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_res_o     (out_res_o),
        .out_tag_o     (out_tag_o),
        .out_status_o  (out_status_o),
        .err_o         (err_o),
        .inflight_o    (inflight_o)
    );

    typedef struct {
        logic        iv;
        logic [4:0]  itag;
        logic        fv;
        logic [31:0] fres;
        logic [4:0]  fst;
        logic        ordy;
        logic        e_irdy;
        logic        e_ovld;
        logic [4:0]  e_otag;
        logic [31:0] e_ores;
        logic [4:0]  e_ost;
        logic        e_err;
        logic [2:0]  e_infl;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic iv, input logic [4:0] itag, input logic fv,
                       input logic [31:0] fres, input logic [4:0] fst, input logic ordy,
                       input logic e_irdy, input logic e_ovld, input logic [4:0] e_otag,
                       input logic [31:0] e_ores, input logic [4:0] e_ost,
                       input logic e_err, input logic [2:0] e_infl);
        vec_t v;
        v.iv = iv; v.itag = itag; v.fv = fv; v.fres = fres; v.fst = fst; v.ordy = ordy;
        v.e_irdy = e_irdy; v.e_ovld = e_ovld; v.e_otag = e_otag; v.e_ores = e_ores;
        v.e_ost = e_ost; v.e_err = e_err; v.e_infl = e_infl;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string nm, input logic irdy, input logic ovld,
                              input logic [4:0] otag, input logic [31:0] ores,
                              input logic [4:0] ost, input logic err, input logic [2:0] infl);
        chk({nm, ".issue_ready"}, 32'(issue_ready_o), 32'(irdy));
        chk({nm, ".out_valid"},   32'(out_valid_o),   32'(ovld));
        chk({nm, ".out_tag"},     32'(out_tag_o),     32'(otag));
        chk({nm, ".out_res"},     out_res_o,          ores);
        chk({nm, ".out_status"},  32'(out_status_o),  32'(ost));
        chk({nm, ".err"},         32'(err_o),         32'(err));
        chk({nm, ".inflight"},    32'(inflight_o),    32'(infl));
    endtask

    task automatic drive(input logic iv, input logic [4:0] itag, input logic fv,
                         input logic [31:0] fres, input logic [4:0] fst, input logic ordy);
        issue_valid_i = iv;
        issue_tag_i   = itag;
        fma_valid_i   = fv;
        fma_res_i     = fres;
        fma_status_i  = fst;
        out_ready_i   = ordy;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        drive(1'b0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
    endtask

    initial begin
        logic prev_irdy;

        // Single op: issue tag 7, result three cycles later, then drain.
        add(1, 7, 0, 32'h0, 0, 1,            1, 0, 0, 32'h0, 0, 0, 1);
        add(0, 0, 0, 32'h0, 0, 1,            1, 0, 0, 32'h0, 0, 0, 1);
        add(0, 0, 0, 32'h0, 0, 1,            1, 0, 0, 32'h0, 0, 0, 1);
        add(0, 0, 1, 32'h40400000, 0, 1,     1, 1, 7, 32'h40400000, 0, 0, 1);
        add(0, 0, 0, 32'h0, 0, 1,            1, 0, 0, 32'h0, 0, 0, 0);
        // Fill four credits with the consumer stalled.
        add(1, 1, 0, 32'h0, 0, 0,            1, 0, 0, 32'h0, 0, 0, 1);
        add(1, 2, 0, 32'h0, 0, 0,            1, 0, 0, 32'h0, 0, 0, 2);
        add(1, 3, 0, 32'h0, 0, 0,            1, 0, 0, 32'h0, 0, 0, 3);
        add(1, 4, 0, 32'h0, 0, 0,            0, 0, 0, 32'h0, 0, 0, 4);
        add(0, 0, 1, 32'h3f800001, 1, 0,     0, 1, 1, 32'h3f800001, 1, 0, 4);
        add(0, 0, 0, 32'h0, 0, 1,            1, 0, 0, 32'h0, 0, 0, 3);
        add(0, 0, 1, 32'h40000002, 2, 0,     1, 1, 2, 32'h40000002, 2, 0, 3);
        // Push and pop on a one-entry result FIFO: head advances, valid stays high.
        add(0, 0, 1, 32'h40400003, 3, 1,     1, 1, 3, 32'h40400003, 3, 0, 2);
        // Issue and drain together at cnt=2.
        add(1, 9, 0, 32'h0, 0, 1,            1, 0, 0, 32'h0, 0, 0, 2);
        add(0, 0, 1, 32'h40800004, 4, 0,     1, 1, 4, 32'h40800004, 4, 0, 2);
        add(0, 0, 1, 32'h40a00009, 0, 0,     1, 1, 4, 32'h40800004, 4, 0, 2);
        add(0, 0, 0, 32'h0, 0, 1,            1, 1, 9, 32'h40a00009, 0, 0, 1);
        add(0, 0, 0, 32'h0, 0, 1,            1, 0, 0, 32'h0, 0, 0, 0);
        // Ordering: tags 10..13 back-to-back, results back-to-back with no bubbles.
        for (int i = 0; i < 4; i++) begin
            add(1, 5'(10 + i), 0, 32'h0, 0, 1, (i != 3), 0, 0, 32'h0, 0, 0, 3'(i + 1));
        end
        for (int i = 0; i < 4; i++) begin
            add(0, 0, 1, 32'h41200000 + 32'(i) * 32'h00100000, 5'(i), 1,
                (i != 0), 1, 5'(10 + i), 32'h41200000 + 32'(i) * 32'h00100000, 5'(i), 0,
                3'(4 - i));
        end
        add(0, 0, 0, 32'h0, 0, 1,            1, 0, 0, 32'h0, 0, 0, 0);
        // Result with no outstanding tag.
        add(0, 0, 1, 32'h12345678, 5'h1f, 1, 1, 0, 0, 32'h0, 0, 1, 0);

        #1;
        check_outs("reset", 1, 0, 0, 32'h0, 0, 0, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();

        prev_irdy = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].itag, vecs[i].fv, vecs[i].fres, vecs[i].fst, vecs[i].ordy);
            @(negedge clk_i);
            chk($sformatf("row%0d.pre_edge_issue_ready", i), 32'(issue_ready_o), 32'(prev_irdy));
            step();
            check_outs($sformatf("row%0d", i), vecs[i].e_irdy, vecs[i].e_ovld, vecs[i].e_otag,
                       vecs[i].e_ores, vecs[i].e_ost, vecs[i].e_err, vecs[i].e_infl);
            prev_irdy = vecs[i].e_irdy;
        end

        // Issue while full: ignored, flagged.
        apply_reset();
        check_outs("reset2", 1, 0, 0, 32'h0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 5'(20 + k), 1'b0, 32'h0, 5'd0, 1'b0);
            step();
        end
        check_outs("full", 0, 0, 0, 32'h0, 0, 0, 4);
        drive(1'b1, 5'd24, 1'b0, 32'h0, 5'd0, 1'b0);
        step();
        check_outs("issue_when_full", 0, 0, 0, 32'h0, 0, 1, 4);

        // Backpressure: head held stable for five stalled cycles.
        drive(1'b0, 5'd0, 1'b1, 32'hc0490fdb, 5'h10, 1'b0);
        step();
        check_outs("bp_first", 0, 1, 20, 32'hc0490fdb, 5'h10, 1, 4);
        drive(1'b0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step();
            check_outs($sformatf("bp_hold%0d", k), 0, 1, 20, 32'hc0490fdb, 5'h10, 1, 4);
        end
        drive(1'b0, 5'd0, 1'b1, 32'h3e000015, 5'd1, 1'b0);
        step();
        drive(1'b0, 5'd0, 1'b1, 32'h3e000016, 5'd2, 1'b0);
        step();
        drive(1'b0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0);
        check_outs("three_buffered", 0, 1, 20, 32'hc0490fdb, 5'h10, 1, 4);

        // Asynchronous reset with three entries buffered.
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check_outs("async_reset", 1, 0, 0, 32'h0, 0, 0, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
        check_outs("after_reset", 1, 0, 0, 32'h0, 0, 0, 0);

        // A result still in flight from before reset is flagged and dropped.
        drive(1'b0, 5'd0, 1'b1, 32'h3e000017, 5'd3, 1'b1);
        step();
        drive(1'b0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0);
        check_outs("late_result", 1, 0, 0, 32'h0, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_fma_result_buf.md
# fp_fma_result_buf

Result-collection stage directly downstream of the single-precision FMA wrapper. The FMA pipeline has no backpressure, drops operation tags, and pulses a one-cycle valid per result. This block issues credits to the dispatcher, records each issued tag in order, pairs every returning result with its tag, and buffers tag, result and status for a valid/ready consumer, typically core writeback.

## Interface
- DEPTH, 4: buffer entries and maximum in-flight operations (issued but not yet drained); power of two, ≥2
- TAG_WIDTH, 5: width of the operation tag (destination register id)
- STAT_WIDTH, 5: width of the FMA status flags
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- issue_valid_i  in  1  dispatcher starts an FMA operation this cycle (mirrors FMA En_i)
- issue_tag_i  in  TAG_WIDTH  tag of the issued operation
- issue_ready_o  out  1  a credit is available; issue_valid_i is legal only when this is high
- fma_valid_i  in  1  FMA result valid pulse (FMA Valid_o)
- fma_res_i  in  32  FMA result (FMA Res_o)
- fma_status_i  in  STAT_WIDTH  FMA status flags (FMA Status_o)
- out_valid_o  out  1  buffered result available
- out_ready_i  in  1  consumer accepts the head entry
- out_res_o  out  32  head result
- out_tag_o  out  TAG_WIDTH  head tag
- out_status_o  out  STAT_WIDTH  head status
- err_o  out  1  sticky protocol error flag
- inflight_o  out  $clog2(DEPTH+1)  credits in use

## Operation
- Tag FIFO, DEPTH entries: push issue_tag_i on issue = issue_valid_i & issue_ready_o. Pop on every fma_valid_i while non-empty.
- Result FIFO, DEPTH entries, holding {tag, res, status}: push on fma_valid_i. The stored tag is the tag FIFO head popped in the same cycle. Results return in issue order, so this pairing is exact.
- Credit counter cnt: +1 on issue, −1 on drain = out_valid_o & out_ready_i. Both in one cycle leaves cnt unchanged. inflight_o = cnt.
- issue_ready_o = (cnt < DEPTH), decoded from the registered cnt only. There is no combinational path from out_ready_i. At cnt == DEPTH with a drain in the same cycle, issue_ready_o stays low that cycle.
- Because cnt bounds both FIFOs, neither FIFO can overflow under legal use.
- Error cases set err_o. Once set, err_o stays high until reset. No other state changes in these cases.
  - issue_valid_i while issue_ready_o is low: the issue is ignored.
  - fma_valid_i while the tag FIFO is empty: the result is dropped.
- out_* outputs present the result FIFO head. They are held stable while out_valid_o & !out_ready_i.
- Results and status pass through unmodified. No arithmetic is performed besides pointer and counter updates.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty is tracked with an explicit occupancy count per FIFO.

## Timing
- Reset values: issue_ready_o=1, out_valid_o=0, out_res_o=0, out_tag_o=0, out_status_o=0, err_o=0, inflight_o=0. Both FIFOs are empty.
- Reset asserted mid-operation discards all entries and credits. FMA results still in flight after reset are flagged as errors, because the tag FIFO is empty. The dispatcher must reset together with the FMA.
- Latency: fma_valid_i at cycle N gives out_valid_o at cycle N+1. There is no same-cycle bypass.
- Issue at cycle N gives inflight_o incremented at N+1.
- Simultaneous push and pop on a full result FIFO cannot occur legally. On a FIFO holding one entry, simultaneous push and pop keeps out_valid_o high and advances the head.
- Back-to-back fma_valid_i every cycle is supported at full throughput while out_ready_i=1.

## Structure
- Package fp_pkg holds:
  - typedef fp_res_entry_t = packed struct {tag, res[31:0], status}, parameterised through package localparams FP_TAG_WIDTH and FP_STAT_WIDTH
  - localparam FP_RES_BUF_DEPTH
- One generic sub-module, fp_sync_fifo (parameters DATA_WIDTH, DEPTH; push/pop/full/empty/data). It is instantiated twice: tag FIFO and result FIFO.
- The credit counter and error logic sit in the top level.

## Test plan
- Single op: issue tag 7; after 3 cycles fma_valid_i with res 0x40400000, status 0 → at the next cycle out_valid_o=1, out_tag_o=7, out_res_o=0x40400000. Drain → inflight_o returns to 0.
- Fill: issue tags 1,2,3,4 with out_ready_i=0 (DEPTH=4) → issue_ready_o=0 and inflight_o=4. One drain → issue_ready_o=1 on the following cycle, not the same cycle.
- Ordering: issue tags 10..13 back-to-back and return 4 consecutive results → outputs are drained in order 10..13 with matching results and no bubbles.
- Backpressure: hold out_ready_i=0 for 5 cycles with an entry present → out_* remain stable. Simultaneous issue and drain at cnt=2 → cnt stays at 2.
- Errors: fma_valid_i with no issue outstanding → err_o=1, out_valid_o stays 0. Issue while full → err_o=1, inflight_o unchanged.
- Reset mid-run: assert rst_ni low with 3 entries buffered → all outputs return to reset values in the same cycle (asynchronous).
